// File: rtl/rvc_pkg.sv
// Shared RV32I encoding constants and instruction-format builders used by
// the RVC expansion stage.
package rvc_pkg;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] SYSTEM = 7'h73;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_PRIV = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b000_0000;
    localparam logic [6:0] F7_ALT  = 7'b010_0000;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // Branch and jump builders take the offset without its always-zero bit 0.
    function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

endpackage

// File: rtl/rvc_expander_if.sv
// Fetch-to-decode channel through the RVC expansion stage: input side,
// output side and redirect flush.
interface rvc_expander_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        in_compressed;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        out_compressed;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_inst, in_compressed, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_next_pc, out_compressed, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_compressed, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_next_pc, out_compressed, out_illegal
    );
endinterface

// File: rtl/rvc_expand_comb.sv
// Purely combinational RV32C half-word to RV32I word expander; reserved and
// unsupported encodings raise illegal and produce the canonical NOP.
module rvc_expand_comb
    import rvc_pkg::*;
(
    input  logic [15:0] c,
    output logic [31:0] inst,
    output logic        illegal
);

    logic [4:0]  rd, rs2, rd_p, rs1_p;
    logic [9:0]  addi4spn_imm;
    logic [6:0]  lw_off;
    logic [11:0] imm6_s, addi16sp_imm, lwsp_off, swsp_off;
    logic [19:0] lui_imm;
    logic [12:1] b_off;
    logic [20:1] j_off;
    logic        nz6_zero;

    // Primed fields (3 bits) address x8..x15.
    assign rd    = c[11:7];
    assign rs2   = c[6:2];
    assign rd_p  = {2'b01, c[4:2]};
    assign rs1_p = {2'b01, c[9:7]};

    assign addi4spn_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign lw_off       = {c[5], c[12:10], c[6], 2'b00};
    assign imm6_s       = {{7{c[12]}}, c[6:2]};
    assign addi16sp_imm = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    assign lui_imm      = {{14{c[12]}}, c[12], c[6:2]};
    assign lwsp_off     = {4'b0000, c[3:2], c[12], c[6:4], 2'b00};
    assign swsp_off     = {4'b0000, c[8:7], c[12:9], 2'b00};
    assign b_off        = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
    assign j_off        = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    assign nz6_zero     = ({c[12], c[6:2]} == 6'd0);

    always_comb begin
        // NOTE: every output gets a default before the case tree so no path can infer a latch.
        inst    = NOP_INST;
        illegal = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: if (c[12:5] == 8'd0) illegal = 1'b1;
                            else inst = enc_i({2'b00, addi4spn_imm}, 5'd2, F3_ADD, rd_p, OP_IMM);
                    3'b010: inst = enc_i({5'd0, lw_off}, rs1_p, F3_LW, rd_p, LOAD);
                    3'b110: inst = enc_s({5'd0, lw_off}, rd_p, rs1_p, F3_SW, STORE);
                    default: illegal = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: inst = enc_i(imm6_s, rd, F3_ADD, rd, OP_IMM);
                    3'b001: inst = enc_j(j_off, 5'd1, JAL);
                    3'b010: inst = enc_i(imm6_s, 5'd0, F3_ADD, rd, OP_IMM);
                    3'b011: begin
                        if (rd == 5'd2) begin
                            if (nz6_zero) illegal = 1'b1;
                            else inst = enc_i(addi16sp_imm, 5'd2, F3_ADD, 5'd2, OP_IMM);
                        end else if (nz6_zero && rd != 5'd0) begin
                            illegal = 1'b1;
                        end else begin
                            inst = enc_u(lui_imm, rd, LUI);
                        end
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00, 2'b01: if (c[12]) illegal = 1'b1;
                                          else inst = enc_i({c[10] ? F7_ALT : F7_ZERO, c[6:2]},
                                                            rs1_p, F3_SR, rs1_p, OP_IMM);
                            2'b10: inst = enc_i(imm6_s, rs1_p, F3_AND, rs1_p, OP_IMM);
                            default: begin
                                if (c[12]) illegal = 1'b1;
                                else begin
                                    case (c[6:5])
                                        2'b00: inst = enc_r(F7_ALT, rd_p, rs1_p, F3_ADD, rs1_p, OP);
                                        2'b01: inst = enc_r(F7_ZERO, rd_p, rs1_p, F3_XOR, rs1_p, OP);
                                        2'b10: inst = enc_r(F7_ZERO, rd_p, rs1_p, F3_OR, rs1_p, OP);
                                        default: inst = enc_r(F7_ZERO, rd_p, rs1_p, F3_AND, rs1_p, OP);
                                    endcase
                                end
                            end
                        endcase
                    end
                    3'b101: inst = enc_j(j_off, 5'd0, JAL);
                    3'b110: inst = enc_b(b_off, 5'd0, rs1_p, F3_BEQ, BRANCH);
                    default: inst = enc_b(b_off, 5'd0, rs1_p, F3_BNE, BRANCH);
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: if (c[12]) illegal = 1'b1;
                            else inst = enc_i({F7_ZERO, c[6:2]}, rd, F3_SLL, rd, OP_IMM);
                    3'b010: if (rd == 5'd0) illegal = 1'b1;
                            else inst = enc_i(lwsp_off, 5'd2, F3_LW, rd, LOAD);
                    3'b100: begin
                        // rs2 == 0 selects the jump forms; bit 12 picks link vs. plain.
                        if (!c[12]) begin
                            if (rs2 != 5'd0) inst = enc_r(F7_ZERO, rs2, 5'd0, F3_ADD, rd, OP);
                            else if (rd == 5'd0) illegal = 1'b1;
                            else inst = enc_i(12'd0, rd, 3'b000, 5'd0, JALR);
                        end else begin
                            if (rs2 != 5'd0) inst = enc_r(F7_ZERO, rs2, rd, F3_ADD, rd, OP);
                            else if (rd == 5'd0) inst = enc_i(12'd1, 5'd0, F3_PRIV, 5'd0, SYSTEM);
                            else inst = enc_i(12'd0, rd, 3'b000, 5'd1, JALR);
                        end
                    end
                    3'b110: inst = enc_s(swsp_off, rs2, 5'd2, F3_SW, STORE);
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rvc_expander.sv
// Registered RV32C expansion stage: one output register under valid/ready
// flow control with flush, plus the fall-through PC adder.
module rvc_expander #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = rvc_pkg::NOP_INST
) (
    input logic           clk,
    input logic           rst,
    rvc_expander_if.slave bus
);

    logic [31:0]     exp_inst;
    logic            exp_illegal;
    logic [31:0]     load_inst;
    logic            load_illegal;
    logic            load;

    logic            valid_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc_q;
    logic            compressed_q;
    logic            illegal_q;

    rvc_expand_comb u_expand (
        .c       (bus.in_inst[15:0]),
        .inst    (exp_inst),
        .illegal (exp_illegal)
    );

    always_comb begin
        load_inst    = bus.in_inst;
        load_illegal = (bus.in_inst[1:0] != 2'b11);
        if (bus.in_compressed) begin
            load_inst    = exp_illegal ? NOP_INST : exp_inst;
            load_illegal = exp_illegal;
        end
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            valid_q      <= 1'b0;
            inst_q       <= NOP_INST;
            pc_q         <= '0;
            next_pc_q    <= '0;
            compressed_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q      <= 1'b1;
            inst_q       <= load_inst;
            pc_q         <= bus.in_pc;
            next_pc_q    <= bus.in_pc + (bus.in_compressed ? XLEN'(2) : XLEN'(4));
            compressed_q <= bus.in_compressed;
            illegal_q    <= load_illegal;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_inst       = inst_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_next_pc    = next_pc_q;
    assign bus.out_compressed = compressed_q;
    assign bus.out_illegal    = illegal_q;

endmodule

// File: tb/tb_rvc_expander.sv
// Directed bench for rvc_expander: hand-computed expansion vectors streamed
// back-to-back, then backpressure, flush and reset-during-stall scenarios.
module tb_rvc_expander;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        comp;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    logic [31:0] tb_pc = 32'h0;

    always #5 clk = ~clk;

    rvc_expander_if bus ();

    rvc_expander dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic comp, input logic [31:0] inst, input logic [31:0] exp,
                       input logic ill);
        vec_t v;
        v.comp = comp; v.inst = inst; v.pc = tb_pc; v.exp = exp; v.ill = ill;
        vecs.push_back(v);
        tb_pc = tb_pc + (comp ? 32'd2 : 32'd4);
    endtask

    task automatic add_at(input logic [31:0] pc, input logic comp, input logic [31:0] inst,
                          input logic [31:0] exp, input logic ill);
        tb_pc = pc;
        add(comp, inst, exp, ill);
    endtask

    task automatic drive(input logic comp, input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid      = 1'b1;
        bus.in_compressed = comp;
        bus.in_inst       = inst;
        bus.in_pc         = pc;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, " valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, " inst"}, bus.out_inst, v.exp);
        check({tag, " illegal"}, {31'd0, bus.out_illegal}, {31'd0, v.ill});
        check({tag, " pc"}, bus.out_pc, v.pc);
        check({tag, " next_pc"}, bus.out_next_pc, v.pc + (v.comp ? 32'd2 : 32'd4));
        check({tag, " compressed"}, {31'd0, bus.out_compressed}, {31'd0, v.comp});
    endtask

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_inst       = '0;
        bus.in_compressed = 1'b0;
        bus.in_pc         = '0;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b1;

        add_at(32'h100, 1, 32'h0040, 32'h0041_0413, 0);
        add(1, 32'h4515, 32'h0050_0513, 0);
        add(1, 32'h852E, 32'h00B0_0533, 0);
        add_at(32'h200, 0, 32'h00A0_0093, 32'h00A0_0093, 0);
        add(1, 32'h0000, NOP, 1);
        add(1, 32'h4002, NOP, 1);
        add(1, 32'h4144, 32'h0045_2483, 0);
        add(1, 32'hC504, 32'h0095_2423, 0);
        add(1, 32'h12FD, 32'hFFF2_8293, 0);
        add(1, 32'h2801, 32'h0100_00EF, 0);
        add(1, 32'h7139, 32'hFC01_0113, 0);
        add(1, 32'h6785, 32'h0000_17B7, 0);
        add(1, 32'h840D, 32'h4034_5413, 0);
        add(1, 32'h98F9, 32'hFFE4_F493, 0);
        add(1, 32'h8C05, 32'h4094_0433, 0);
        add(1, 32'h8D4D, 32'h00B5_6533, 0);
        add(1, 32'h9C05, NOP, 1);
        add(1, 32'hBFFD, 32'hFFFF_F06F, 0);
        add(1, 32'hC401, 32'h0004_0463, 0);
        add(1, 32'hFCF5, 32'hFE04_9EE3, 0);
        add(1, 32'h0392, 32'h0043_9393, 0);
        add(1, 32'h1392, NOP, 1);
        add(1, 32'h4432, 32'h00C1_2403, 0);
        add(1, 32'h8082, 32'h0000_8067, 0);
        add(1, 32'h8002, NOP, 1);
        add(1, 32'h9002, 32'h0010_0073, 0);
        add(1, 32'h9282, 32'h0002_80E7, 0);
        add(1, 32'h952E, 32'h00B5_0533, 0);
        add(1, 32'hC42E, 32'h00B1_2423, 0);
        add(1, 32'h2000, NOP, 1);
        add(1, 32'h0004, NOP, 1);
        add(1, 32'h6101, NOP, 1);
        add(1, 32'h6781, NOP, 1);
        add(1, 32'h9001, NOP, 1);
        add(1, 32'h4015, 32'h0050_0013, 0);
        add(1, 32'h0001, 32'h0000_0013, 0);
        add(1, 32'h0003, NOP, 1);
        add(0, 32'h1234_5671, 32'h1234_5671, 1);
        add_at(32'hFFFF_FFFE, 1, 32'h4515, 32'h0050_0513, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst inst", bus.out_inst, NOP);
        check("rst illegal", {31'd0, bus.out_illegal}, 32'd0);
        check("rst compressed", {31'd0, bus.out_compressed}, 32'd0);
        check("rst pc", bus.out_pc, 32'd0);
        check("rst next_pc", bus.out_next_pc, 32'd0);
        check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Back-to-back stream: each vector must appear on the very next cycle.
        drive(vecs[0].comp, vecs[0].inst, vecs[0].pc);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_out($sformatf("v%0d", i), vecs[i]);
            if (i + 1 < vecs.size()) drive(vecs[i+1].comp, vecs[i+1].inst, vecs[i+1].pc);
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("drain valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: hold A for three cycles while B waits, then replace in one edge.
        bus.out_ready = 1'b0;
        drive(1, 32'h4515, 32'h300);
        @(negedge clk);
        drive(1, 32'h852E, 32'h302);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d valid", k), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("stall%0d inst", k), bus.out_inst, 32'h0050_0513);
            check($sformatf("stall%0d pc", k), bus.out_pc, 32'h300);
            check($sformatf("stall%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release valid", {31'd0, bus.out_valid}, 32'd1);
        check("release inst", bus.out_inst, 32'h00B0_0533);
        check("release pc", bus.out_pc, 32'h302);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("release drain", {31'd0, bus.out_valid}, 32'd0);

        // Flush while holding: held word and the presented word both vanish.
        bus.out_ready = 1'b0;
        drive(1, 32'h0040, 32'h400);
        @(negedge clk);
        check("flush held valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1, 32'h4515, 32'h402);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        check("flush dropped", {31'd0, bus.out_valid}, 32'd0);

        // Reset during a stall drops the held instruction.
        drive(1, 32'h0000, 32'h502);
        @(negedge clk);
        check("prerst illegal", {31'd0, bus.out_illegal}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst inst", bus.out_inst, NOP);
        check("midrst illegal", {31'd0, bus.out_illegal}, 32'd0);
        check("midrst compressed", {31'd0, bus.out_compressed}, 32'd0);
        check("midrst pc", bus.out_pc, 32'd0);
        check("midrst next_pc", bus.out_next_pc, 32'd0);
        check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rvc_expander.md
# rvc_expander

Registered RV32C-to-RV32I expansion stage between the fetch-side address alignment block and the decoder. Takes one fetched instruction per handshake (a 16-bit half-word with a `compressed` flag, or a full 32-bit word), expands compressed encodings to their 32-bit equivalents, and flags reserved or unsupported encodings. Computes the fall-through PC, then holds the result in a single output register under valid/ready flow control, with flush support for redirects.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width; only 32 is supported.
- `NOP_INST`, 32'h0000_0013, word substituted on an illegal encoding.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input instruction valid.
- `in_ready`  out  1  stage can accept input this cycle.
- `in_inst`  in  32  instruction, little-endian corrected; upper 16 bits are zero when compressed.
- `in_compressed`  in  1  1 means `in_inst[15:0]` is an RVC encoding.
- `in_pc`  in  32  address of the instruction.
- `flush`  in  1  drop held and incoming instruction (branch redirect).
- `out_valid`  out  1  output register holds an instruction.
- `out_ready`  in  1  decoder accepts output.
- `out_inst`  out  32  expanded or passed-through RV32I word.
- `out_pc`  out  32  registered `in_pc`.
- `out_next_pc`  out  32  `out_pc + 2` if compressed, else `out_pc + 4`; mod 2^32.
- `out_compressed`  out  1  registered `in_compressed`.
- `out_illegal`  out  1  encoding is reserved or unsupported.

## Operation
- `in_ready = !out_valid || out_ready`, combinational; no skid entry.
- Load occurs when `in_valid && in_ready && !flush`: all `out_*` registers update and `out_valid` is set to 1.
- When `out_valid && out_ready` with no load, `out_valid` clears; data registers hold their values.
- `flush` has priority over load. It clears `out_valid` next cycle and discards the input presented that cycle.
- Passthrough: when `in_compressed = 0`, `out_inst = in_inst`.
  - If `in_inst[1:0] != 2'b11`, then `out_illegal = 1`.
- Expansion, quadrant 0: C.ADDI4SPN, C.LW, C.SW.
- Expansion, quadrant 1: C.NOP/C.ADDI, C.JAL, C.LI, C.ADDI16SP, C.LUI, C.SRLI, C.SRAI, C.ANDI, C.SUB, C.XOR, C.OR, C.AND, C.J, C.BEQZ, C.BNEZ.
- Expansion, quadrant 2: C.SLLI, C.LWSP, C.JR, C.MV, C.EBREAK, C.JALR, C.ADD, C.SWSP.
- Register and immediate rules:
  - 3-bit register fields map to x8–x15.
  - Immediates are sign- or zero-extended per the RVC spec.
  - C.JAL writes x1.
  - C.JALR writes x1 with offset 0.
  - C.MV expands to `add rd,x0,rs2`.
  - C.ADD expands to `add rd,rd,rs2`.
- Illegal encodings, each producing `out_inst = NOP_INST` and `out_illegal = 1`:
  - Half-word 16'h0000.
  - ADDI4SPN with nzuimm = 0.
  - ADDI16SP with imm = 0.
  - C.LUI with imm = 0 (rd ≠ x0, x2).
  - C.LWSP with rd = 0.
  - C.JR with rs1 = 0.
  - Any shift with shamt[5] = 1.
  - All FP loads/stores (C.FLD, C.FLW, C.FSD, C.FSW and SP-relative forms).
  - Reserved quadrant-1 funct (bit12 = 1 with ALU ops).
  - `in_compressed = 1` with `in_inst[1:0] == 2'b11`.
- Hint encodings (e.g. C.ADDI rd = 0, C.LI rd = 0, C.MV rd = 0) expand normally and are legal.
- `out_compressed` and `out_next_pc` are registered alongside the expanded word.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready = 1`.
- Reset values:
  - `out_valid = 0`, `out_illegal = 0`, `out_compressed = 0`.
  - `out_inst = NOP_INST`.
  - `out_pc = 0`, `out_next_pc = 0`.
  - `in_ready = 1` in the cycle after reset deasserts.
- Reset during a held instruction drops it; no output is produced.
- Stall: `out_*` stays stable while `out_valid && !out_ready`.
- Simultaneous `out_ready` and new input: replace in the same edge, no bubble.
- `out_next_pc` wraps: PC 32'hFFFF_FFFE compressed gives 32'h0000_0000.

## Structure
- Shared package `rvc_pkg` holds:
  - Opcode constants: OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, SYSTEM.
  - Funct3/funct7 constants.
  - `NOP_INST`.
- Sub-module `rvc_expand_comb` is purely combinational: 16-bit in, 32-bit plus illegal out.
- The top level holds only the handshake register and PC adder.

## Test plan
- C.ADDI4SPN: 16'h0040 at PC 0x100 → `out_inst` 32'h0041_0413, `out_next_pc` 0x102, `out_illegal` 0.
- C.LI x10,5: 16'h4515 → 32'h0050_0513. C.MV x10,x11: 16'h852E → 32'h00B0_0533. Send back-to-back with `out_ready = 1` → consecutive cycles, no bubble.
- Uncompressed passthrough: 32'h00A0_0093 at PC 0x200 → same word, `out_next_pc` 0x204.
- Illegal: 16'h0000 → `out_inst` 32'h0000_0013, `out_illegal` 1. C.LWSP rd = 0 (16'h4002) → `out_illegal` 1.
- Backpressure: hold `out_ready = 0` for 3 cycles → output stable, `in_ready` 0. Release → next instruction loads the same edge.
- `flush` asserted with `in_valid` while holding → `out_valid` 0 next cycle, input dropped. `rst` mid-stall → all outputs at reset values.
